// File: rtl/pe_array_ctrl.sv
// Sequencer for a ROWS x COLS Life PE array: loads a pattern cell by cell,
// runs a programmable number of generations (stopping early once the array
// is stable), then streams the final array contents out row-major.
module pe_array_ctrl #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int GEN_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                load_en,
   input  logic [GEN_BITS-1:0] gen_count,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic                ld_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                rd_data,
   output logic                rd_last,
   output logic                busy,
   output logic                done,
   output logic                stable,
   output logic [GEN_BITS-1:0] gens_done,
   output logic [1:0]          cmd,
   output logic [ROWS-1:0]     rsel_i,
   output logic [COLS-1:0]     csel_i,
   output logic                state_in,
   output logic [ROWS-1:0]     rsel_o,
   output logic [COLS-1:0]     csel_o,
   input  logic                array_state,
   input  logic                array_active
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_READ = 2'd3;

   localparam logic [1:0] CMD_NOP     = 2'd0;
   localparam logic [1:0] CMD_PROCESS = 2'd1;
   localparam logic [1:0] CMD_WRITE   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [RW-1:0]       r_q, r_d, r_next;
   logic [CW-1:0]       c_q, c_d, c_next;
   logic [GEN_BITS-1:0] g_q, g_d, g_inc;
   logic [GEN_BITS-1:0] cnt_q, cnt_d;
   logic                stable_q, stable_d;
   logic                ld_done_q, ld_done_d;
   logic                done_q, done_d;
   logic [1:0]          cmd_q, cmd_d;
   logic [ROWS-1:0]     rsel_i_q, rsel_i_d, rsel_o_q, rsel_o_d;
   logic [COLS-1:0]     csel_i_q, csel_i_d, csel_o_q, csel_o_d;
   logic                state_in_q, state_in_d;
   logic                cell_last, ld_hs, rd_hs;

   function automatic logic [ROWS-1:0] row_onehot(input logic [RW-1:0] idx);
      return ROWS'(1) << idx;
   endfunction

   function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] idx);
      return COLS'(1) << idx;
   endfunction

   // Generation counter never wraps; it pins at all-ones.
   function automatic logic [GEN_BITS-1:0] sat_inc(input logic [GEN_BITS-1:0] v);
      return (v == {GEN_BITS{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign cell_last = (r_q == R_LAST) && (c_q == C_LAST);
   assign c_next    = (c_q == C_LAST) ? '0 : c_q + 1'b1;
   assign r_next    = (c_q != C_LAST) ? r_q : ((r_q == R_LAST) ? '0 : r_q + 1'b1);
   assign g_inc     = sat_inc(g_q);

   // ld_done_q marks the extra LOAD cycle in which the last cell's WRITE is on the bus.
   assign ld_ready  = (state_q == S_LOAD) && !ld_done_q;
   assign ld_hs     = ld_ready && ld_valid;
   assign rd_valid  = (state_q == S_READ);
   assign rd_hs     = rd_valid && rd_ready;
   assign rd_data   = rd_valid && array_state;
   assign rd_last   = rd_valid && cell_last;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign stable    = stable_q;
   assign gens_done = g_q;
   assign cmd       = cmd_q;
   assign rsel_i    = rsel_i_q;
   assign csel_i    = csel_i_q;
   assign state_in  = state_in_q;
   assign rsel_o    = rsel_o_q;
   assign csel_o    = csel_o_q;

   // Next-state logic; command and write selects default to an idle bus every cycle.
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      c_d        = c_q;
      g_d        = g_q;
      cnt_d      = cnt_q;
      stable_d   = stable_q;
      ld_done_d  = ld_done_q;
      done_d     = 1'b0;
      cmd_d      = CMD_NOP;
      rsel_i_d   = '0;
      csel_i_d   = '0;
      state_in_d = 1'b0;
      rsel_o_d   = rsel_o_q;
      csel_o_d   = csel_o_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d     = gen_count;
               stable_d  = 1'b0;
               g_d       = '0;
               r_d       = '0;
               c_d       = '0;
               ld_done_d = 1'b0;
               if (load_en) begin
                  state_d = S_LOAD;
               end else if (gen_count != '0) begin
                  state_d = S_RUN;
                  cmd_d   = CMD_PROCESS;
               end else begin
                  state_d  = S_READ;
                  rsel_o_d = row_onehot('0);
                  csel_o_d = col_onehot('0);
               end
            end
         end
         S_LOAD: begin
            if (ld_done_q) begin
               ld_done_d = 1'b0;
               if (cnt_q != '0) begin
                  state_d = S_RUN;
                  cmd_d   = CMD_PROCESS;
               end else begin
                  state_d  = S_READ;
                  rsel_o_d = row_onehot('0);
                  csel_o_d = col_onehot('0);
               end
            end else if (ld_hs) begin
               cmd_d      = CMD_WRITE;
               rsel_i_d   = row_onehot(r_q);
               csel_i_d   = col_onehot(c_q);
               state_in_d = ld_data;
               r_d        = r_next;
               c_d        = c_next;
               ld_done_d  = cell_last;
            end
         end
         S_RUN: begin
            g_d = g_inc;
            if (!array_active) begin
               stable_d = 1'b1;
            end
            if (!array_active || (g_inc >= cnt_q)) begin
               state_d  = S_READ;
               r_d      = '0;
               c_d      = '0;
               rsel_o_d = row_onehot('0);
               csel_o_d = col_onehot('0);
            end else begin
               cmd_d = CMD_PROCESS;
            end
         end
         S_READ: begin
            if (rd_hs) begin
               if (cell_last) begin
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
                  r_d      = '0;
                  c_d      = '0;
                  rsel_o_d = '0;
                  csel_o_d = '0;
               end else begin
                  r_d      = r_next;
                  c_d      = c_next;
                  rsel_o_d = row_onehot(r_next);
                  csel_o_d = col_onehot(c_next);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any job in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         c_q        <= '0;
         g_q        <= '0;
         cnt_q      <= '0;
         stable_q   <= 1'b0;
         ld_done_q  <= 1'b0;
         done_q     <= 1'b0;
         cmd_q      <= CMD_NOP;
         rsel_i_q   <= '0;
         csel_i_q   <= '0;
         state_in_q <= 1'b0;
         rsel_o_q   <= '0;
         csel_o_q   <= '0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         c_q        <= c_d;
         g_q        <= g_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         ld_done_q  <= ld_done_d;
         done_q     <= done_d;
         cmd_q      <= cmd_d;
         rsel_i_q   <= rsel_i_d;
         csel_i_q   <= csel_i_d;
         state_in_q <= state_in_d;
         rsel_o_q   <= rsel_o_d;
         csel_o_q   <= csel_o_d;
      end
   end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: an 8x8 Life PE array environment plus a
// generation-level reference model and a per-cycle compare process.
module tb_pe_array_ctrl;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int GB   = 16;
   localparam int N    = ROWS * COLS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          load_en = 1'b0;
   logic [GB-1:0] gen_count = '0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic          ld_data = 1'b0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic          rd_data;
   logic          rd_last;
   logic          busy;
   logic          done;
   logic          stable;
   logic [GB-1:0] gens_done;
   logic [1:0]    cmd;
   logic [ROWS-1:0] rsel_i, rsel_o;
   logic [COLS-1:0] csel_i, csel_o;
   logic          state_in;
   logic          array_state;
   logic          array_active;

   pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_BITS(GB)) dut (
      .clk(clk), .rst(rst), .start(start), .load_en(load_en), .gen_count(gen_count),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .done(done), .stable(stable), .gens_done(gens_done),
      .cmd(cmd), .rsel_i(rsel_i), .csel_i(csel_i), .state_in(state_in),
      .rsel_o(rsel_o), .csel_o(csel_o),
      .array_state(array_state), .array_active(array_active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One Life generation on an 8x8 grid with dead cells beyond the edge.
   function automatic logic [63:0] life_step(input logic [63:0] g);
      logic [63:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                     if (g[rr*COLS+cc]) cnt++;
               end
            end
            n[r*COLS+c] = g[r*COLS+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      end
      return n;
   endfunction

   // PE array environment
   logic [63:0] pe_q = '0;
   logic [63:0] rd_mask;

   always @(posedge clk) begin
      if (cmd == 2'd2) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               if (rsel_i[r] && csel_i[c]) pe_q[r*COLS+c] <= state_in;
      end else if (cmd == 2'd1) begin
         pe_q <= life_step(pe_q);
      end
   end

   always_comb begin
      rd_mask = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            rd_mask[r*COLS+c] = rsel_o[r] & csel_o[c];
      array_state  = |(pe_q & rd_mask);
      array_active = (life_step(pe_q) != pe_q);
   end

   // Scoreboard state
   logic [63:0] pat = '0;
   logic [63:0] model_grid = '0;
   logic [63:0] exp_rd = '0;
   int ld_idx = 0, wr_cnt = 0, proc_cnt = 0, beat = 0, done_cnt = 0;
   bit last_hs_prev = 1'b0;
   int wq[$];

   // Per-cycle compare process
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ld_idx = 0; wr_cnt = 0; proc_cnt = 0; beat = 0; done_cnt = 0;
            last_hs_prev = 1'b0;
            wq.delete();
         end else begin
            chk("sel_onehot", 64'({$onehot0(rsel_i), $onehot0(csel_i), $onehot0(rsel_o), $onehot0(csel_o)}), 64'hF);
            chk("sel_exclusive", 64'(((|rsel_i) || (|csel_i)) && ((|rsel_o) || (|csel_o))), 64'd0);
            chk("gens_done_track", 64'(gens_done), 64'(proc_cnt));
            chk("done_timing", 64'(done), 64'(last_hs_prev));
            if (done) done_cnt++;
            last_hs_prev = rd_valid && rd_ready && (beat == N - 1);
            case (cmd)
               2'd2: begin
                  wr_cnt++;
                  if (wq.size() == 0) begin
                     chk("write_after_beat", 64'd0, 64'd1);
                  end else begin
                     e = wq.pop_front();
                     chk("write_rsel", 64'(rsel_i), 64'(1) << ((e >> 1) / COLS));
                     chk("write_csel", 64'(csel_i), 64'(1) << ((e >> 1) % COLS));
                     chk("write_data", 64'(state_in), 64'(e & 1));
                  end
               end
               2'd1: begin
                  proc_cnt++;
                  chk("process_sel", 64'({rsel_i, csel_i, rsel_o, csel_o}), 64'd0);
               end
               2'd3: chk("cmd_legal", 64'(cmd), 64'd0);
               default: ;
            endcase
            if (ld_valid && ld_ready) begin
               wq.push_back(ld_idx * 2 + int'(ld_data));
               ld_idx++;
            end
            if (rd_valid) begin
               if (beat < N) begin
                  chk("rd_data", 64'(rd_data), 64'(exp_rd[beat]));
                  chk("rd_last", 64'(rd_last), 64'(beat == N - 1));
                  chk("read_rsel", 64'(rsel_o), 64'(1) << (beat / COLS));
                  chk("read_csel", 64'(csel_o), 64'(1) << (beat % COLS));
               end else begin
                  chk("rd_extra_beat", 64'(beat), 64'(N - 1));
               end
               if (rd_ready) beat++;
            end
            if (start && !busy) begin
               ld_idx = 0; wr_cnt = 0; proc_cnt = 0; beat = 0; done_cnt = 0;
               wq.delete();
            end
         end
      end
   end

   task automatic run_job(input string tag, input bit le, input int gc, input bit bp,
                          input bit poke, input int lit_gens, input bit lit_stable,
                          input bit pin, input logic [63:0] lit_final);
      logic [63:0] g, nx;
      int eg;
      bit es, seen;
      g  = le ? pat : model_grid;
      eg = 0;
      es = 1'b0;
      for (int i = 0; i < gc; i++) begin
         nx = life_step(g);
         eg++;
         if (nx == g) begin
            es = 1'b1;
            break;
         end
         g = nx;
      end
      chk({tag, "_model_gens"}, 64'(eg), 64'(lit_gens));
      chk({tag, "_model_stable"}, 64'(es), 64'(lit_stable));
      if (pin) chk({tag, "_model_grid"}, g, lit_final);
      exp_rd     = g;
      model_grid = g;

      @(posedge clk); #1;
      start = 1'b1; load_en = le; gen_count = GB'(gc);
      @(posedge clk); #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         ld_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_data  = pat[(ld_idx < N) ? ld_idx : 0];
         rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = poke && rd_valid && (beat == 5);
         load_en  = 1'b1;
         @(posedge clk); #1;
         if (done_cnt != 0) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0;
      chk({tag, "_completed"}, 64'(seen), 64'd1);
      chk({tag, "_gens_done"}, 64'(gens_done), 64'(eg));
      chk({tag, "_stable"}, 64'(stable), 64'(es));
      chk({tag, "_process_cycles"}, 64'(proc_cnt), 64'(eg));
      chk({tag, "_write_cycles"}, 64'(wr_cnt), le ? 64'(N) : 64'd0);
      chk({tag, "_beats"}, 64'(beat), 64'(N));
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, "_idle_after"}, 64'({busy, rd_valid}), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk({tag, "_stays_idle"}, 64'({busy, done}), 64'd0);
      end
   endtask

   localparam logic [63:0] BLINKER_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BLINKER_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLOCK     = 64'h0000_0018_1800_0000;
   localparam logic [63:0] GLIDER_MX = 64'hC0C0_0000_0007_0402;

   initial begin
      bit reached;
      // Power-on reset
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({busy, done, stable, ld_ready, rd_valid, rd_last, rd_data, cmd, state_in}), 64'd0);
      chk("reset_selects", 64'({rsel_i, csel_i, rsel_o, csel_o}), 64'd0);
      chk("reset_gens", 64'(gens_done), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-RUN
      pat = BLINKER_H;
      start = 1'b1; load_en = 1'b1; gen_count = 16'd1000;
      @(posedge clk); #1;
      start = 1'b0; ld_valid = 1'b1; rd_ready = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 400; i++) begin
         ld_data = pat[(ld_idx < N) ? ld_idx : 0];
         @(posedge clk); #1;
         if (proc_cnt >= 5) begin
            reached = 1'b1;
            break;
         end
      end
      chk("midrun_reached", 64'(reached), 64'd1);
      chk("midrun_busy", 64'({busy, cmd}), 64'({1'b1, 2'd1}));
      rst = 1'b0; ld_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("midreset_outputs", 64'({busy, done, stable, ld_ready, rd_valid, cmd, state_in}), 64'd0);
         chk("midreset_selects", 64'({rsel_i, csel_i, rsel_o, csel_o}), 64'd0);
         chk("midreset_gens", 64'(gens_done), 64'd0);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("postreset_quiet", 64'({busy, done, cmd}), 64'd0);
      end

      run_job("blinker1", 1'b1, 1,  1'b0, 1'b0, 1, 1'b0, 1'b1, BLINKER_V);
      run_job("blinker2", 1'b1, 2,  1'b0, 1'b0, 2, 1'b0, 1'b1, BLINKER_H);
      pat = BLOCK;
      run_job("block",    1'b1, 10, 1'b0, 1'b0, 1, 1'b1, 1'b1, BLOCK);
      pat = GLIDER_MX;
      run_job("backpres", 1'b1, 3,  1'b1, 1'b0, 3, 1'b0, 1'b0, '0);
      run_job("noload0",  1'b0, 0,  1'b0, 1'b1, 0, 1'b0, 1'b0, '0);
      pat = BLINKER_H;
      run_job("load_gen0", 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, BLINKER_H);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
